alu_cmd_sequencer: RTL and testbench

Command front-end that sits directly upstream of the 32-bit combinational ALU. It accepts one command per handshake, reads operands from a local 8×32 register file or an immediate, and drives the ALU's operand and opcode inputs from registers. It captures the ALU result one cycle later, writes it back to the register file, and presents it downstream through a valid/ready response port.

---
 rtl/alu_cmd_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: single-command-in-flight front-end for a 32-bit
// combinational ALU. Accepts a command, reads operands from a local register
// file (or an immediate), drives registered ALU inputs, captures the result
// one cycle later, writes it back and offers it on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int NREGS = 8,
  parameter int IDX_W = $clog2(NREGS),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [IDX_W-1:0] cmd_dst,
  input  logic [IDX_W-1:0] cmd_src1,
  input  logic [IDX_W-1:0] cmd_src2,
  input  logic             cmd_use_imm,
  input  logic [31:0]      cmd_imm,
  output logic [31:0]      alu_operand1,
  output logic [31:0]      alu_operand2,
  output logic [3:0]       alu_opcode,
  input  logic [31:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [IDX_W-1:0] rsp_dst,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] cmd_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic             illegal_q, illegal_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      regs_q [NREGS];
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [31:0]      wr_data;
  logic [31:0]      src1_val;
  logic [31:0]      src2_val;

  // Opcodes outside the ALU's supported set never write the register file.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op == 4'b0101) || (op >= 4'b1010);
  endfunction

  // R0 is hard-wired to zero on the read side; it is also never written.
  assign src1_val = (cmd_src1 == '0) ? 32'd0 : regs_q[cmd_src1];
  assign src2_val = (cmd_src2 == '0) ? 32'd0 : regs_q[cmd_src2];

  assign cmd_ready    = (state_q == IDLE);
  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign alu_opcode   = opcode_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_dst      = dst_q;
  assign rsp_illegal  = illegal_q;
  assign cmd_count    = count_q;

  // Next-state and writeback decode for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    opcode_d    = opcode_q;
    dst_d       = dst_q;
    illegal_d   = illegal_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    count_d     = count_q;
    wr_en       = 1'b0;
    wr_addr     = dst_q;
    wr_data     = alu_result;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          opcode_d  = cmd_opcode;
          op1_d     = src1_val;
          op2_d     = cmd_use_imm ? cmd_imm : src2_val;
          dst_d     = cmd_dst;
          illegal_d = op_illegal(cmd_opcode);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_result;
        wr_en       = !illegal_q && (dst_q != '0);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          count_d     = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All sequencer state and the register file; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      opcode_q    <= '0;
      dst_q       <= '0;
      illegal_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      opcode_q    <= opcode_d;
      dst_q       <= dst_d;
      illegal_q   <= illegal_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      count_q     <= count_d;
      if (wr_en) begin
        regs_q[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios followed by a
// randomized run, all checked against a register/count model of the block.
// The response counter is instantiated narrower than its default width so the
// wrap-around can be reached in a short run.
module tb_alu_cmd_sequencer;
  localparam int CNT_W = 10;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [2:0]       cmd_dst;
  logic [2:0]       cmd_src1;
  logic [2:0]       cmd_src2;
  logic             cmd_use_imm;
  logic [31:0]      cmd_imm;
  logic [31:0]      alu_operand1;
  logic [31:0]      alu_operand2;
  logic [3:0]       alu_opcode;
  logic [31:0]      alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [2:0]       rsp_dst;
  logic             rsp_illegal;
  logic [CNT_W-1:0] cmd_count;

  int checks = 0;
  int failures = 0;

  // Reference state: architectural registers and completed-response count.
  logic [31:0]      m_regs [8];
  logic [CNT_W-1:0] m_count;

  alu_cmd_sequencer #(.NREGS(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_dst(rsp_dst), .rsp_illegal(rsp_illegal), .cmd_count(cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU arithmetic rules; also used as the combinational ALU the DUT drives.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return (a == 32'd0) ? 32'd1 : 32'd0;
      4'd8:    return a << 1;
      4'd9:    return a >> 1;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_opcode, alu_operand1, alu_operand2);

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'd5) || (op >= 4'd10);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    return (idx == 3'd0) ? 32'd0 : m_regs[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    m_count = '0;
  endtask

  // One complete command. Entered and left #1 after a rising edge with the DUT idle.
  // 'stall' cycles of rsp_ready=0 are inserted in RESP; 'hold_valid' keeps
  // cmd_valid asserted (with altered fields) during that time.
  task automatic do_cmd(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] s1,
                        input logic [2:0] s2, input logic ui, input logic [31:0] imm,
                        input int stall, input logic hold_valid, output logic [31:0] res);
    logic [31:0] e1, e2, er;
    logic        eill;
    e1   = m_read(s1);
    e2   = ui ? imm : m_read(s2);
    er   = alu_fn(op, e1, e2);
    eill = is_illegal(op);
    cmd_opcode = op; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2;
    cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
    rsp_ready = (stall == 0);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;                       // accept edge N
    cmd_valid = hold_valid;
    if (hold_valid) begin
      cmd_use_imm = 1'b1;
      cmd_imm     = ~imm;
    end
    check("rsp_valid_n", 32'(rsp_valid), 32'd0);
    check("cmd_ready_exec", 32'(cmd_ready), 32'd0);
    check("alu_operand1", alu_operand1, e1);
    check("alu_operand2", alu_operand2, e2);
    check("alu_opcode", 32'(alu_opcode), 32'(op));
    @(posedge clk); #1;                       // edge N+1: response up
    check("rsp_valid_n1", 32'(rsp_valid), 32'd1);
    check("rsp_data", rsp_data, er);
    check("rsp_dst", 32'(rsp_dst), 32'(dst));
    check("rsp_illegal", 32'(rsp_illegal), 32'(eill));
    if (!eill && dst != 3'd0) m_regs[dst] = er;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_rsp_data", rsp_data, er);
      check("stall_rsp_dst", 32'(rsp_dst), 32'(dst));
      check("stall_rsp_illegal", 32'(rsp_illegal), 32'(eill));
      check("stall_no_accept", alu_operand2, e2);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;                       // response taken
    cmd_valid = 1'b0;
    m_count = m_count + 1'b1;
    check("rsp_valid_done", 32'(rsp_valid), 32'd0);
    check("cmd_count", 32'(cmd_count), 32'(m_count));
    check("cmd_ready_back", 32'(cmd_ready), 32'd1);
    $display("cmd op=%0d dst=%0d s1=%0d s2=%0d imm=%0d/0x%08h stall=%0d -> data=0x%08h ill=%0d count=%0d",
             op, dst, s1, s2, ui, imm, stall, rsp_data, rsp_illegal, cmd_count);
    res = er;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_dst"}, 32'(rsp_dst), 32'd0);
    check({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'd0);
    check({tag, "_op1"}, alu_operand1, 32'd0);
    check({tag, "_op2"}, alu_operand2, 32'd0);
    check({tag, "_opcode"}, 32'(alu_opcode), 32'd0);
    check({tag, "_count"}, 32'(cmd_count), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_opcode = '0; cmd_dst = '0; cmd_src1 = '0; cmd_src2 = '0;
    cmd_use_imm = 1'b0; cmd_imm = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // add chain through R1 into R2, then read R2 back
    do_cmd(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, 0, 1'b0, r);
    check("r1_is_5", r, 32'd5);
    do_cmd(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 32'hFFFF_FFFE, 0, 1'b0, r);
    check("r2_is_3", r, 32'd3);
    do_cmd(4'd0, 3'd0, 3'd2, 3'd0, 1'b1, 32'd0, 0, 1'b0, r);
    check("read_r2", rsp_data, 32'd3);

    // mul low word, sub wrap, shr1
    do_cmd(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'h0001_0000, 0, 1'b0, r);
    do_cmd(4'd2, 3'd3, 3'd1, 3'd1, 1'b0, 32'd0, 0, 1'b0, r);
    check("mul_low32", rsp_data, 32'd0);
    do_cmd(4'd1, 3'd4, 3'd0, 3'd0, 1'b1, 32'd1, 0, 1'b0, r);
    check("sub_wrap", rsp_data, 32'hFFFF_FFFF);
    do_cmd(4'd9, 3'd5, 3'd4, 3'd0, 1'b0, 32'd0, 0, 1'b0, r);
    check("shr1", rsp_data, 32'h7FFF_FFFF);

    // illegal opcode 0101 must not disturb R6
    do_cmd(4'd0, 3'd6, 3'd0, 3'd0, 1'b1, 32'd7, 0, 1'b0, r);
    do_cmd(4'd5, 3'd6, 3'd1, 3'd2, 1'b1, 32'd1, 0, 1'b0, r);
    check("illegal_flag", 32'(rsp_illegal), 32'd1);
    check("illegal_data", rsp_data, 32'd0);
    do_cmd(4'd0, 3'd0, 3'd6, 3'd0, 1'b1, 32'd0, 0, 1'b0, r);
    check("r6_kept", rsp_data, 32'd7);

    // back-pressure for 10 cycles with cmd_valid held high
    do_cmd(4'd6, 3'd3, 3'd6, 3'd5, 1'b0, 32'd0, 10, 1'b1, r);
    do_cmd(4'd7, 3'd2, 3'd0, 3'd0, 1'b0, 32'd0, 0, 1'b0, r);
    check("not_of_zero", rsp_data, 32'd1);

    // reset during EXEC of R7 <- or(R0, 0xA5)
    cmd_opcode = 4'd4; cmd_dst = 3'd7; cmd_src1 = 3'd0; cmd_use_imm = 1'b1;
    cmd_imm = 32'h0000_00A5; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("exec_before_reset", alu_operand2, 32'h0000_00A5);
    rst = 1'b1;
    #1;
    model_reset();
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_cmd(4'd0, 3'd0, 3'd7, 3'd0, 1'b1, 32'd0, 0, 1'b0, r);
    check("r7_zero", rsp_data, 32'd0);

    // randomized traffic until the response counter has wrapped to 1
    for (int n = 0; n < (1 << CNT_W); n++) begin
      logic [3:0]  op;
      logic [2:0]  d, a, b;
      logic        ui;
      logic [31:0] imm;
      int          st;
      op  = 4'($urandom_range(0, 15));
      d   = 3'($urandom_range(0, 7));
      a   = 3'($urandom_range(0, 7));
      b   = 3'($urandom_range(0, 7));
      ui  = 1'($urandom_range(0, 1));
      imm = $urandom();
      st  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      do_cmd(op, d, a, b, ui, imm, st, 1'($urandom_range(0, 1)), r);
    end
    check("count_wrapped", 32'(cmd_count), 32'd1);

    // R0 write is discarded but still answered
    do_cmd(4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 32'd9, 0, 1'b0, r);
    check("r0_write_data", rsp_data, 32'd9);
    do_cmd(4'd4, 3'd0, 3'd0, 3'd0, 1'b0, 32'd0, 0, 1'b0, r);
    check("r0_reads_zero", rsp_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
